// File: rtl/join_barrier.sv
// Join point: collects per-lane arrival pulses and raises a registered "all arrived" handshake.
// Latency: done_valid rises one cycle after the last required arrival, or after an arm with an empty effective mask.
// Backpressure: done_valid holds until done_ready is sampled high; arm_ready is low outside IDLE.
module join_barrier #(
  parameter int N_INS = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm_valid,
  output logic             arm_ready,
  input  logic [N_INS-1:0] arm_mask,
  input  logic [N_INS-1:0] arrive,
  input  logic             abort,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [N_INS-1:0] pending,
  output logic [CNT_W-1:0] wait_cycles
);

  // Lane counts outside 2..32 are a configuration error, not a degenerate barrier.
  if (N_INS < 2 || N_INS > 32) begin : g_n_ins_range
    $error("join_barrier: N_INS must be within 2..32");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_INS-1:0] pending_nxt;
  logic [CNT_W-1:0] wait_nxt;
  logic [N_INS-1:0] arm_pending;
  logic [N_INS-1:0] armed_pending;

  // Both handshake outputs decode straight from the state flop, so arrive
  // never reaches done_valid combinationally.
  assign arm_ready  = (state == IDLE);
  assign done_valid = (state == DONE);

  // Arrivals in the arm cycle already count against the new mask; in ARMED,
  // clearing with ~arrive makes repeated or unselected arrivals no-ops.
  assign arm_pending   = arm_mask & ~arrive;
  assign armed_pending = pending & ~arrive;

  // Next-state, next-pending and wait counter; abort overrides everything.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    wait_nxt    = wait_cycles;
    case (state)
      IDLE: begin
        if (arm_valid) begin
          pending_nxt = arm_pending;
          wait_nxt    = '0;
          state_nxt   = (arm_pending == '0) ? DONE : ARMED;
        end
      end
      ARMED: begin
        pending_nxt = armed_pending;
        wait_nxt    = (wait_cycles == '1) ? wait_cycles : wait_cycles + CNT_W'(1);
        if (armed_pending == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        pending_nxt = '0;
        if (done_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
      end
    endcase
    // Abort discards any arm in flight and swallows a pending completion;
    // the wait counter keeps whatever it had.
    if (abort) begin
      state_nxt   = IDLE;
      pending_nxt = '0;
      wait_nxt    = wait_cycles;
    end
  end

  // State, pending mask and wait counter registers; reset clears a join mid-flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      wait_cycles <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      wait_cycles <= wait_nxt;
    end
  end

endmodule

// File: tb/tb_join_barrier.sv
module tb_join_barrier;

  localparam int N = 8;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         arm_valid;
  logic         arm_ready;
  logic [N-1:0] arm_mask;
  logic [N-1:0] arrive;
  logic         abort;
  logic         done_valid;
  logic         done_ready;
  logic [N-1:0] pending;
  logic [W-1:0] wait_cycles;

  int passed;
  int total;

  join_barrier #(.N_INS(N), .CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm_valid  (arm_valid),
    .arm_ready  (arm_ready),
    .arm_mask   (arm_mask),
    .arrive     (arrive),
    .abort      (abort),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .pending    (pending),
    .wait_cycles(wait_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst        = 1'b1;
    arm_valid  = 1'b0;
    arm_mask   = '0;
    arrive     = '0;
    abort      = 1'b0;
    done_ready = 1'b0;
    #1;
    chk("rst_arm_ready", 32'(arm_ready), 32'h1);
    chk("rst_done_valid", 32'(done_valid), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_wait", 32'(wait_cycles), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Basic join: arm 0x0F at c0, arrivals at c2, c4, c7.
    tick();                                   // c0
    arm_valid = 1'b1; arm_mask = 8'h0F;
    tick();                                   // c1
    arm_valid = 1'b0;
    chk("basic_arm_ready_low", 32'(arm_ready), 32'h0);
    chk("basic_pending_armed", 32'(pending), 32'h0F);
    chk("basic_wait_start", 32'(wait_cycles), 32'h0);
    tick();                                   // c2
    arrive = 8'h01;
    tick();                                   // c3
    arrive = 8'h00;
    chk("basic_pending_0e", 32'(pending), 32'h0E);
    tick();                                   // c4
    arrive = 8'h06;
    tick();                                   // c5
    arrive = 8'h00;
    chk("basic_pending_08", 32'(pending), 32'h08);
    chk("basic_no_early_done", 32'(done_valid), 32'h0);
    tick();                                   // c6
    tick();                                   // c7
    arrive = 8'h08;
    chk("basic_done_not_yet", 32'(done_valid), 32'h0);
    tick();                                   // c8
    arrive = 8'h00;
    chk("basic_done_valid", 32'(done_valid), 32'h1);
    chk("basic_wait_7", 32'(wait_cycles), 32'h7);
    chk("basic_pending_0", 32'(pending), 32'h0);
    tick();                                   // c9
    chk("basic_done_held", 32'(done_valid), 32'h1);
    tick();                                   // c10
    done_ready = 1'b1;
    tick();                                   // c11
    done_ready = 1'b0;
    chk("basic_release_arm_ready", 32'(arm_ready), 32'h1);
    chk("basic_release_done_low", 32'(done_valid), 32'h0);
    chk("basic_wait_held", 32'(wait_cycles), 32'h7);

    // Same-cycle arrival and duplicate arrival.
    arm_valid = 1'b1; arm_mask = 8'h03; arrive = 8'h01;
    tick();
    arm_valid = 1'b0; arrive = 8'h01;
    chk("dup_pending_after_arm", 32'(pending), 32'h02);
    tick();
    arrive = 8'h02;
    chk("dup_pending_unchanged", 32'(pending), 32'h02);
    chk("dup_no_done", 32'(done_valid), 32'h0);
    tick();
    arrive = 8'h00; done_ready = 1'b1;
    chk("dup_done", 32'(done_valid), 32'h1);
    chk("dup_wait_2", 32'(wait_cycles), 32'h2);
    tick();
    done_ready = 1'b0;
    chk("dup_idle", 32'(arm_ready), 32'h1);

    // Empty mask completes on the next cycle with zero wait.
    arm_valid = 1'b1; arm_mask = 8'h00;
    tick();
    arm_valid = 1'b0;
    chk("empty_done", 32'(done_valid), 32'h1);
    chk("empty_wait_0", 32'(wait_cycles), 32'h0);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("empty_idle", 32'(arm_ready), 32'h1);

    // Arrivals on unselected lanes are ignored.
    arm_valid = 1'b1; arm_mask = 8'h10; arrive = 8'h0F;
    tick();
    arm_valid = 1'b0;
    chk("ignore_pending_arm", 32'(pending), 32'h10);
    tick();
    tick();
    chk("ignore_pending_hold", 32'(pending), 32'h10);
    chk("ignore_no_done", 32'(done_valid), 32'h0);
    arrive = 8'h10;
    tick();
    arrive = 8'h00; done_ready = 1'b1;
    chk("ignore_done", 32'(done_valid), 32'h1);
    tick();
    done_ready = 1'b0;

    // Abort in ARMED with pending 0x04.
    arm_valid = 1'b1; arm_mask = 8'h07;
    tick();
    arm_valid = 1'b0; arrive = 8'h03;
    tick();
    arrive = 8'h00;
    chk("abort_pending_04", 32'(pending), 32'h04);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(arm_ready), 32'h1);
    chk("abort_pending_clr", 32'(pending), 32'h0);
    chk("abort_wait_held", 32'(wait_cycles), 32'h1);
    arrive = 8'h04;
    tick();
    arrive = 8'h00;
    chk("abort_no_done", 32'(done_valid), 32'h0);

    // Abort wins over an arm in the same cycle.
    arm_valid = 1'b1; arm_mask = 8'h01; abort = 1'b1;
    tick();
    arm_valid = 1'b0; abort = 1'b0;
    chk("abort_arm_idle", 32'(arm_ready), 32'h1);
    chk("abort_arm_pending", 32'(pending), 32'h0);
    chk("abort_arm_wait_held", 32'(wait_cycles), 32'h1);

    // Abort with done_ready in DONE.
    arm_valid = 1'b1; arm_mask = 8'h00;
    tick();
    arm_valid = 1'b0;
    chk("abort_done_in_done", 32'(done_valid), 32'h1);
    abort = 1'b1; done_ready = 1'b1;
    tick();
    abort = 1'b0; done_ready = 1'b0;
    chk("abort_done_idle", 32'(arm_ready), 32'h1);
    chk("abort_done_low", 32'(done_valid), 32'h0);

    // Saturation over a 40-cycle join, then backpressure with arm_valid held.
    arm_valid = 1'b1; arm_mask = 8'h80;
    tick();
    arm_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("sat_wait_15", 32'(wait_cycles), 32'hF);
    chk("sat_no_done", 32'(done_valid), 32'h0);
    arrive = 8'h80;
    tick();
    arrive = 8'h00; arm_valid = 1'b1; arm_mask = 8'h01;
    chk("sat_done", 32'(done_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_done_held", 32'(done_valid), 32'h1);
      chk("bp_arm_ready_low", 32'(arm_ready), 32'h0);
    end
    chk("bp_wait_held", 32'(wait_cycles), 32'hF);
    arm_valid = 1'b0; done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("bp_idle", 32'(arm_ready), 32'h1);
    chk("bp_pending_0", 32'(pending), 32'h0);

    // Asynchronous reset between edges while ARMED.
    arm_valid = 1'b1; arm_mask = 8'hFF;
    tick();
    arm_valid = 1'b0;
    tick();
    chk("arst_pre_pending", 32'(pending), 32'hFF);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pending", 32'(pending), 32'h0);
    chk("arst_arm_ready", 32'(arm_ready), 32'h1);
    chk("arst_wait", 32'(wait_cycles), 32'h0);
    chk("arst_done", 32'(done_valid), 32'h0);
    #1;
    rst = 1'b0;
    tick();
    arm_valid = 1'b1; arm_mask = 8'h01; arrive = 8'h01;
    tick();
    arm_valid = 1'b0; arrive = 8'h00;
    chk("arst_rearm_done", 32'(done_valid), 32'h1);
    chk("arst_rearm_wait", 32'(wait_cycles), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
